// File: rtl/fifo_ag_param.sv
// fifo_ag_param: parametrised first-word-fall-through valid/ready FIFO (any depth >= 2); a pushed word reaches the head one cycle later.
// dataInReady falls at full, during flush and while reset is high; define FIFOAG_HWM_EN to add the highWater occupancy tracker.
module fifo_ag_param #(
    parameter int DATA_WIDTH      = 32,
    parameter int FIFO_DEPTH      = 8,
    parameter int ALMOST_FULL_TH  = 6,
    parameter int ALMOST_EMPTY_TH = 2,
    localparam int CW             = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  dataInValid,
    output logic                  dataInReady,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  dataOutValid,
    input  logic                  dataOutReady,
    output logic [CW-1:0]         fillLevel,
    output logic                  almostFull,
    output logic                  almostEmpty
`ifdef FIFOAG_HWM_EN
    ,
    output logic [CW-1:0]         highWater
`endif
);

    localparam int            PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_TH);
    localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_TH);
    localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         fill_q, fill_d;
    logic                  push;
    logic                  pop;

    // Ready depends on state and control only, so no valid->ready combinational loop.
    assign dataInReady  = !reset && !flush && (fill_q != DEPTH_C);
    assign dataOutValid = (fill_q != '0);
    assign dataOut      = dataOutValid ? mem_q[rd_ptr_q] : '0;
    assign push         = dataInValid && dataInReady;
    assign pop          = dataOutValid && dataOutReady;

    assign fillLevel    = fill_q;
    assign almostFull   = (fill_q >= AF_C);
    assign almostEmpty  = (fill_q <= AE_C);

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop)      fill_d = fill_q + CW'(1);
            else if (pop && !push) fill_d = fill_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= dataIn;
    end

`ifdef FIFOAG_HWM_EN
    logic [CW-1:0] hwm_q, hwm_d;

    always_comb begin
        hwm_d = hwm_q;
        if (flush)                hwm_d = '0;
        else if (fill_d > hwm_q)  hwm_d = fill_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) hwm_q <= '0;
        else       hwm_q <= hwm_d;
    end

    assign highWater = hwm_q;
`else
    // Occupancy history is not kept in this build; fillLevel is the only occupancy output.
`endif

endmodule

// File: tb/tb_fifo_ag_param.sv
// Bench for fifo_ag_param: a depth-8 and a depth-5 instance checked every cycle against queue-based models.
module tb_fifo_ag_param;

    localparam int DEP [2] = '{8, 5};
    localparam int AFT [2] = '{6, 4};
    localparam int AET [2] = '{2, 1};

    logic        clk;
    logic        rst;
    logic [31:0] din  [2];
    logic        div  [2];
    logic        dor  [2];
    logic        fl_i [2];
    logic        rnd_en;

    logic [31:0] dout8, dout5;
    logic        dir8, dir5, dov8, dov5, af8, af5, ae8, ae5;
    logic [3:0]  fill8;
    logic [2:0]  fill5;
`ifdef FIFOAG_HWM_EN
    logic [3:0]  hw8;
    logic [2:0]  hw5;
`endif

    logic [31:0] mq [2][$];
    int          hwm_m [2];
    int          n_chk;
    int          n_pass;

    fifo_ag_param u_dut8 (
        .clk(clk), .reset(rst), .flush(fl_i[0]),
        .dataIn(din[0]), .dataInValid(div[0]), .dataInReady(dir8),
        .dataOut(dout8), .dataOutValid(dov8), .dataOutReady(dor[0]),
        .fillLevel(fill8), .almostFull(af8), .almostEmpty(ae8)
`ifdef FIFOAG_HWM_EN
        , .highWater(hw8)
`endif
    );

    fifo_ag_param #(.DATA_WIDTH(32), .FIFO_DEPTH(5), .ALMOST_FULL_TH(4), .ALMOST_EMPTY_TH(1)) u_dut5 (
        .clk(clk), .reset(rst), .flush(fl_i[1]),
        .dataIn(din[1]), .dataInValid(div[1]), .dataInReady(dir5),
        .dataOut(dout5), .dataOutValid(dov5), .dataOutReady(dor[1]),
        .fillLevel(fill5), .almostFull(af5), .almostEmpty(ae5)
`ifdef FIFOAG_HWM_EN
        , .highWater(hw5)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Compare one DUT against its model, then advance the model by the transfer at the coming edge.
    task automatic check_dut(input int k);
        int          sz;
        logic        exp_rdy;
        logic [31:0] exp_dat;
        string       p;
        p = (k == 0) ? "d8" : "d5";
        if (rst) begin
            mq[k].delete();
            hwm_m[k] = 0;
        end
        sz      = mq[k].size();
        exp_rdy = !rst && !fl_i[k] && (sz < DEP[k]);
        exp_dat = (sz > 0) ? mq[k][0] : 32'h0;
        chk({p, "_in_ready"},  32'((k == 0) ? dir8 : dir5), 32'(exp_rdy));
        chk({p, "_out_valid"}, 32'((k == 0) ? dov8 : dov5), 32'(sz > 0));
        chk({p, "_fill"},      (k == 0) ? 32'(fill8) : 32'(fill5), 32'(sz));
        chk({p, "_almost_full"},  32'((k == 0) ? af8 : af5), 32'(sz >= AFT[k]));
        chk({p, "_almost_empty"}, 32'((k == 0) ? ae8 : ae5), 32'(sz <= AET[k]));
        chk({p, "_data_out"},  (k == 0) ? dout8 : dout5, exp_dat);
`ifdef FIFOAG_HWM_EN
        chk({p, "_high_water"}, (k == 0) ? 32'(hw8) : 32'(hw5), 32'(hwm_m[k]));
`endif
        if (!rst) begin
            if (fl_i[k]) begin
                mq[k].delete();
                hwm_m[k] = 0;
            end else begin
                if (sz > 0 && dor[k]) void'(mq[k].pop_front());
                if (div[k] && exp_rdy) mq[k].push_back(din[k]);
                if (mq[k].size() > hwm_m[k]) hwm_m[k] = mq[k].size();
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) check_dut(k);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_en) dor[1] = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer one word and hold it until the FIFO takes it.
    task automatic push_word(input int k, input logic [31:0] d);
        logic acc;
        acc    = 1'b0;
        din[k] = d;
        div[k] = 1'b1;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = (k == 0) ? dir8 : dir5;
            cyc();
        end
        div[k] = 1'b0;
        if (!acc) begin
            n_chk++;
            $display("FAIL push_timeout: dut %0d word 0x%0h never accepted, expected acceptance", k, d);
        end
    endtask

    task automatic wait_empty(input int k);
        logic empty;
        empty = 1'b0;
        for (int t = 0; t < 200 && !empty; t++) begin
            if (((k == 0) ? dov8 : dov5) == 1'b0) empty = 1'b1;
            else cyc();
        end
        if (!empty) begin
            n_chk++;
            $display("FAIL drain_timeout: dut %0d still valid, expected empty", k);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rnd_en = 1'b0;
        rst    = 1'b1;
        for (int k = 0; k < 2; k++) begin
            din[k]  = '0;
            div[k]  = 1'b0;
            dor[k]  = 1'b0;
            fl_i[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) cyc();

        // Fill the depth-8 FIFO with the consumer stalled, hold off a ninth word, then drain.
        for (int i = 1; i <= 8; i++) push_word(0, 32'(i));
        chk("d8_full_fill", 32'(fill8), 32'd8);
        din[0] = 32'h9;
        div[0] = 1'b1;
        repeat (3) cyc();
        div[0] = 1'b0;
        dor[0] = 1'b1;
        wait_empty(0);
        dor[0] = 1'b0;

        // Simultaneous push and pop at level 4, then flush at level 5 with a push offered.
        for (int i = 0; i < 4; i++) push_word(0, $urandom);
        din[0] = $urandom;
        div[0] = 1'b1;
        dor[0] = 1'b1;
        cyc();
        div[0] = 1'b0;
        dor[0] = 1'b0;
        chk("d8_pushpop_fill", 32'(fill8), 32'd4);
        push_word(0, $urandom);
        din[0]  = $urandom;
        div[0]  = 1'b1;
        fl_i[0] = 1'b1;
        cyc();
        fl_i[0] = 1'b0;
        div[0]  = 1'b0;
        chk("d8_flush_fill", 32'(fill8), 32'd0);
        chk("d8_flush_valid", 32'(dov8), 32'd0);

        // Reach level 7, drop to 3, then pulse reset between edges.
        for (int i = 0; i < 7; i++) push_word(0, $urandom);
        dor[0] = 1'b1;
        repeat (4) cyc();
        dor[0] = 1'b0;
        chk("d8_pre_reset_fill", 32'(fill8), 32'd3);
        #1;
        rst = 1'b1;
        #1;
        chk("d8_async_fill", 32'(fill8), 32'd0);
        chk("d8_async_valid", 32'(dov8), 32'd0);
        chk("d8_async_data", dout8, 32'd0);
        chk("d8_async_ready", 32'(dir8), 32'd0);
        chk("d8_async_aempty", 32'(ae8), 32'd1);
        chk("d8_async_afull", 32'(af8), 32'd0);
`ifdef FIFOAG_HWM_EN
        chk("d8_async_hwm", 32'(hw8), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc();

        // Depth-5 stream with a randomly stalling consumer exercises pointer wrap.
        rnd_en = 1'b1;
        for (int i = 0; i < 20; i++) push_word(1, $urandom);
        rnd_en = 1'b0;
        cyc();
        dor[1] = 1'b1;
        wait_empty(1);
        dor[1] = 1'b0;
        chk("d5_final_fill", 32'(fill5), 32'd0);
        repeat (2) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
